// File: rtl/mem_walk_pkg.sv
// Shared types and the address-dependent test pattern for the memory walker.
package mem_walk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Pattern seeds, selected by the two low address bits.
    localparam logic [3:0][31:0] BASE = {
        32'hFFFF_FFFF,
        32'h800B_0800,
        32'hAA55_CC33,
        32'h0000_0000
    };

    // Expected word for address a: seed for a[1:0], XORed with the address itself.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return BASE[a[1:0]] ^ a;
    endfunction

endpackage

// File: rtl/mem_walk_cmp.sv
// Read-back checker: compares returned data against the pattern, counts
// mismatches (saturating) and remembers the first failing address.
module mem_walk_cmp
    import mem_walk_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_m,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_cmp_vld,
    input  logic [ADDR_W-1:0] i_cmp_addr,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_pass_ld,
    output logic [7:0]        o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_pass
);

    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_first;
    logic              r_pass;

    logic [DATA_W-1:0] w_exp;
    logic              w_miss;
    logic [7:0]        w_cnt_nxt;

    assign w_exp     = DATA_W'(pat(32'(i_cmp_addr)));
    assign w_miss    = i_cmp_vld && (i_rdata != w_exp);
    assign w_cnt_nxt = (w_miss && (r_cnt != 8'hFF)) ? r_cnt + 8'd1 : r_cnt;

    // Error bookkeeping; pass is judged from the count including the compare
    // landing in the same cycle, so the final DRAIN compare is not missed.
    always_ff @(posedge clk_m) begin
        if (rst || i_clr) begin
            r_cnt   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_miss && (r_cnt == 8'd0))
                r_first <= i_cmp_addr;
            if (i_pass_ld)
                r_pass <= (w_cnt_nxt == 8'd0);
        end
    end

    assign o_err_count      = r_cnt;
    assign o_first_err_addr = r_first;
    assign o_pass           = r_pass;

endmodule

// File: rtl/mem_walk_ctrl.sv
// Write-then-verify sequencer for a single-port block RAM. Writes pat(a) to
// every word, reads everything back, and reports pass/error count/first error.
module mem_walk_ctrl
    import mem_walk_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int LAST_ADDR = 63
) (
    input  logic              clk_m,
    input  logic              rst,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [7:0]        led
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            r_state;
    logic [ADDR_W-1:0] r_a;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_cmp_vld;
    logic [ADDR_W-1:0] r_cmp_addr;

    logic [ADDR_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_start_ok;
    logic              w_pass_ld;
    logic [5:0]        w_led_addr;

    assign w_a_nxt     = r_a + ADDR_W'(1);
    assign w_wdata_nxt = DATA_W'(pat(32'(w_a_nxt)));
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_pass_ld   = (r_state == DRAIN);

    // Sequencer FSM with registered RAM-side and status outputs.
    always_ff @(posedge clk_m) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cmp_vld  <= 1'b0;
            r_cmp_addr <= '0;
        end else begin
            // Read data returns one cycle after the address, so the compare
            // runs on a one-cycle-delayed copy of the read address.
            r_cmp_vld  <= (r_state == READ);
            r_cmp_addr <= r_a;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= WRITE;
                        r_a     <= '0;
                        r_we    <= 1'b1;
                        r_wdata <= DATA_W'(pat(32'd0));
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (r_a == LAST) begin
                        r_state <= READ;
                        r_a     <= '0;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                    end else begin
                        r_a     <= w_a_nxt;
                        r_wdata <= w_wdata_nxt;
                    end
                end
                READ: begin
                    if (r_a == LAST) begin
                        r_state <= DRAIN;
                        r_a     <= '0;
                    end else begin
                        r_a <= w_a_nxt;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mem_walk_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk_m            (clk_m),
        .rst              (rst),
        .i_clr            (w_start_ok),
        .i_cmp_vld        (r_cmp_vld),
        .i_cmp_addr       (r_cmp_addr),
        .i_rdata          (mem_rdata),
        .i_pass_ld        (w_pass_ld),
        .o_err_count      (err_count),
        .o_first_err_addr (first_err_addr),
        .o_pass           (pass)
    );

    assign w_led_addr = 6'(first_err_addr);

    assign mem_we    = r_we;
    assign mem_addr  = r_a;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign led       = {r_done, pass, w_led_addr};

endmodule
